core_regfile_mp: RTL and testbench



---
 rtl/core_pkg.sv | 14 +
 rtl/core_regfile_rdport.sv | 50 +++++
 rtl/core_regfile_mp.sv | 99 +++++++++
 tb/tb_core_regfile_mp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: default widths, the hardwired-zero register index
// and the address-width helper used to size register addresses.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    // Address bits needed to index nreg registers (at least one bit).
    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/core_regfile_rdport.sv
// One registered read port: same-cycle write bypass, data mux over the
// register array and lookup of the post-update busy bit.
module core_regfile_rdport
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int AW     = addr_width(NREG_DEFAULT),
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy_next,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_busy
);

    // wr_en is already qualified against register 0, so a hit never
    // forwards data into a read of x0.
    logic            bypass_hit;
    logic [XLEN-1:0] rd_data_next;

    assign bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

    // Select forwarded write data or the stored register value.
    always_comb begin
        rd_data_next = regs[rd_addr];
        if (bypass_hit) begin
            rd_data_next = wr_data;
        end
    end

    // Capture data and busy when enabled; otherwise hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= rd_data_next;
            rd_busy <= busy_next[rd_addr];
        end
    end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-read-port integer register file with registered reads, optional
// write-to-read bypass and a per-register busy scoreboard for RAW hazards.
//
// Strobe semantics: AWVALID, RSVVALID and each ARVALID bit are single-cycle
// requests sampled on the rising edge of CLK. There is no ready signal; every
// request is accepted in the cycle it is presented and the block never stalls.
module core_regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = addr_width(NREG)
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 AWVALID,
    input  logic [AW-1:0]        AWADDR,
    input  logic [XLEN-1:0]      WDATA,
    input  logic [NRD-1:0]       ARVALID,
    input  logic [NRD*AW-1:0]    ARADDR,
    output logic [NRD*XLEN-1:0]  RDATA,
    output logic [NRD-1:0]       RBUSY,
    input  logic                 RSVVALID,
    input  logic [AW-1:0]        RSVADDR,
    output logic                 RSVERR
);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_next;
    logic                      wr_en;
    logic                      rsv_en;
    logic                      rsverr_next;

    // Register 0 is hardwired to zero: writes and reserves to it are dropped.
    assign wr_en  = AWVALID  && (AWADDR  != AW'(REG_ZERO));
    assign rsv_en = RSVVALID && (RSVADDR != AW'(REG_ZERO));

    // A reserve onto a busy register is an error unless the same cycle's
    // write frees it first.
    assign rsverr_next = rsv_en && busy[RSVADDR] &&
                         !(wr_en && (AWADDR == RSVADDR));

    // Next busy vector: write clears, then reserve sets; bit 0 stays clear.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[AWADDR] = 1'b0;
        end
        if (rsv_en) begin
            busy_next[RSVADDR] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Data storage; entry 0 is only ever written by reset.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[AWADDR] <= WDATA;
        end
    end

    // Busy scoreboard and the one-cycle reserve-error pulse.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            busy   <= '0;
            RSVERR <= 1'b0;
        end else begin
            busy   <= busy_next;
            RSVERR <= rsverr_next;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        core_regfile_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .clk       (CLK),
            .rst_n     (NRST),
            .rd_en     (ARVALID[p]),
            .rd_addr   (ARADDR[p*AW +: AW]),
            .wr_en     (wr_en),
            .wr_addr   (AWADDR),
            .wr_data   (WDATA),
            .regs      (regs),
            .busy_next (busy_next),
            .rd_data   (RDATA[p*XLEN +: XLEN]),
            .rd_busy   (RBUSY[p])
        );
    end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Directed bench for core_regfile_mp: a default instance (32 regs, 2 ports,
// bypass on) and a small instance (16 regs, 4 ports, bypass off).
module tb_core_regfile_mp;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: defaults ----------------
    logic        a_awvalid;
    logic [4:0]  a_awaddr;
    logic [31:0] a_wdata;
    logic [1:0]  a_arvalid;
    logic [9:0]  a_araddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_rsvvalid;
    logic [4:0]  a_rsvaddr;
    logic        a_rsverr;

    core_regfile_mp dut_a (
        .CLK      (clk),
        .NRST     (rst_n),
        .AWVALID  (a_awvalid),
        .AWADDR   (a_awaddr),
        .WDATA    (a_wdata),
        .ARVALID  (a_arvalid),
        .ARADDR   (a_araddr),
        .RDATA    (a_rdata),
        .RBUSY    (a_rbusy),
        .RSVVALID (a_rsvvalid),
        .RSVADDR  (a_rsvaddr),
        .RSVERR   (a_rsverr)
    );

    // ---------------- instance B: 16 regs, 4 ports, no bypass ----------------
    logic         b_awvalid;
    logic [3:0]   b_awaddr;
    logic [31:0]  b_wdata;
    logic [3:0]   b_arvalid;
    logic [15:0]  b_araddr;
    logic [127:0] b_rdata;
    logic [3:0]   b_rbusy;
    logic         b_rsvvalid;
    logic [3:0]   b_rsvaddr;
    logic         b_rsverr;

    core_regfile_mp #(
        .XLEN   (32),
        .NREG   (16),
        .NRD    (4),
        .BYPASS (0)
    ) dut_b (
        .CLK      (clk),
        .NRST     (rst_n),
        .AWVALID  (b_awvalid),
        .AWADDR   (b_awaddr),
        .WDATA    (b_wdata),
        .ARVALID  (b_arvalid),
        .ARADDR   (b_araddr),
        .RDATA    (b_rdata),
        .RBUSY    (b_rbusy),
        .RSVVALID (b_rsvvalid),
        .RSVADDR  (b_rsvaddr),
        .RSVERR   (b_rsverr)
    );

    // ---------------- scoreboard ----------------
    int          checks;
    int          errors;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_awvalid  = 1'b0;
        a_awaddr   = '0;
        a_wdata    = '0;
        a_arvalid  = '0;
        a_araddr   = '0;
        a_rsvvalid = 1'b0;
        a_rsvaddr  = '0;
    endtask

    task automatic b_idle();
        b_awvalid  = 1'b0;
        b_awaddr   = '0;
        b_wdata    = '0;
        b_arvalid  = '0;
        b_araddr   = '0;
        b_rsvvalid = 1'b0;
        b_rsvaddr  = '0;
    endtask

    task automatic a_read(input logic [1:0] en, input logic [4:0] p0, input logic [4:0] p1);
        a_arvalid = en;
        a_araddr  = {p1, p0};
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
        a_awvalid = 1'b1;
        a_awaddr  = addr;
        a_wdata   = data;
    endtask

    task automatic a_reserve(input logic [4:0] addr);
        a_rsvvalid = 1'b1;
        a_rsvaddr  = addr;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data);
        b_awvalid = 1'b1;
        b_awaddr  = addr;
        b_wdata   = data;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_idle();
        b_idle();
        repeat (3) @(posedge clk);
        #1;

        // Outputs while reset is held.
        check("reset_a_rdata", a_rdata, 64'h0);
        check("reset_a_rbusy", a_rbusy, 64'h0);
        check("reset_a_rsverr", a_rsverr, 64'h0);
        check("reset_b_rdata", b_rdata[63:0], 64'h0);
        check("reset_b_rbusy", b_rbusy, 64'h0);
        rst_n = 1'b1;
        step();

        // Sweep every address on both ports of A after reset.
        for (int i = 0; i < 32; i++) begin
            a_read(2'b11, 5'(i), 5'(31 - i));
            exp_q.push_back(64'h0);
            step();
            check("sweep_rdata", a_rdata, exp_q.pop_front());
            check("sweep_rbusy", a_rbusy, 64'h0);
        end
        a_idle();

        // B (no bypass): same-cycle read of x5 sees the old value.
        b_write(4'd5, 32'hDEADBEEF);
        b_arvalid = 4'b0001;
        b_araddr  = 16'h0005;
        step();
        check("nobyp_same_cycle", b_rdata[31:0], 64'h0);
        b_awvalid = 1'b0;
        step();
        check("nobyp_next_cycle", b_rdata[31:0], 64'hDEADBEEF);

        // B: preload x1, x15, x3 then read x5 on every port.
        b_idle();
        b_write(4'd1, 32'h0000_0011);
        step();
        b_write(4'd15, 32'h0000_00FF);
        step();
        b_write(4'd3, 32'h0000_0033);
        step();
        b_idle();
        b_arvalid = 4'b1111;
        b_araddr  = {4'd5, 4'd5, 4'd5, 4'd5};
        step();
        check("b_all_x5_p2", b_rdata[95:64], 64'hDEADBEEF);
        // Port 2 disabled: it must keep x5's value.
        b_arvalid = 4'b1011;
        b_araddr  = {4'd3, 4'd15, 4'd1, 4'd1};
        step();
        check("b_p0_x1", b_rdata[31:0], 64'h11);
        check("b_p1_x1", b_rdata[63:32], 64'h11);
        check("b_p2_hold", b_rdata[95:64], 64'hDEADBEEF);
        check("b_p3_x3", b_rdata[127:96], 64'h33);
        b_idle();

        // A (bypass): same-cycle write/read of x5.
        a_write(5'd5, 32'hDEADBEEF);
        a_read(2'b01, 5'd5, 5'd0);
        step();
        check("byp_same_cycle", a_rdata[31:0], 64'hDEADBEEF);
        a_idle();

        // A: x0 ignores writes and reserves.
        a_write(5'd0, 32'h0000_1234);
        step();
        a_idle();
        a_read(2'b11, 5'd0, 5'd0);
        step();
        check("x0_read", a_rdata, 64'h0);
        a_idle();
        a_reserve(5'd0);
        a_read(2'b01, 5'd0, 5'd0);
        step();
        check("x0_rsv_rbusy", a_rbusy, 64'h0);
        check("x0_rsv_rsverr", a_rsverr, 64'h0);
        a_idle();

        // A: reserve x7 and read it in the same cycle.
        a_reserve(5'd7);
        a_read(2'b01, 5'd7, 5'd0);
        step();
        check("x7_rsv_rbusy", a_rbusy, 64'h1);
        check("x7_rsv_rsverr", a_rsverr, 64'h0);
        a_idle();
        // Write 0x55 to x7 while reading it on port 1; port 0 holds.
        a_write(5'd7, 32'h0000_0055);
        a_read(2'b10, 5'd0, 5'd7);
        step();
        check("x7_wr_rdata", a_rdata[63:32], 64'h55);
        check("x7_wr_rbusy", a_rbusy, 64'h1);
        a_idle();

        // A: double reserve of x9 yields exactly one RSVERR pulse.
        a_reserve(5'd9);
        step();
        check("x9_first_rsverr", a_rsverr, 64'h0);
        step();
        check("x9_second_rsverr", a_rsverr, 64'h1);
        a_idle();
        step();
        check("x9_pulse_end", a_rsverr, 64'h0);
        // Write and reserve x9 together: stays busy, no error.
        a_write(5'd9, 32'h0000_A5A5);
        a_reserve(5'd9);
        a_read(2'b01, 5'd9, 5'd0);
        step();
        check("x9_wr_rsv_rsverr", a_rsverr, 64'h0);
        check("x9_wr_rsv_rbusy", a_rbusy[0], 64'h1);
        check("x9_wr_rsv_rdata", a_rdata[31:0], 64'hA5A5);
        a_idle();

        // Build nonzero outputs, then assert reset between edges.
        a_reserve(5'd9);
        a_read(2'b11, 5'd5, 5'd9);
        step();
        check("pre_rst_rsverr", a_rsverr, 64'h1);
        check("pre_rst_rdata0", a_rdata[31:0], 64'hDEADBEEF);
        check("pre_rst_rbusy", a_rbusy, 64'h2);
        a_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata", a_rdata, 64'h0);
        check("async_rst_rbusy", a_rbusy, 64'h0);
        check("async_rst_rsverr", a_rsverr, 64'h0);
        check("async_rst_b_rdata", b_rdata[127:64], 64'h0);
        step();
        rst_n = 1'b1;
        // Storage and scoreboard were cleared by the reset.
        a_read(2'b11, 5'd5, 5'd9);
        step();
        check("post_rst_rdata", a_rdata, 64'h0);
        check("post_rst_rbusy", a_rbusy, 64'h0);
        a_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
